elev_call_panel: RTL
====================

Name: elev_call_panel

Overview:
- Passenger-side front end for the 4-floor elevator controller.
- Captures raw floor-button presses, holds them as lit pending calls, and picks the next target with SCAN (keep direction, reverse when nothing is ahead).
- Drives the controller's one-hot floor request, then watches its floor-select and door outputs to detect departure and arrival.
- Also drives the active-low 7-segment floor indicator.

Parameters:
- DWELL_CYCLES, 4: minimum cycles door must be seen open at a floor before the next request is issued (≥2).
- LEAVE_TIMEOUT, 3: cycles to wait for door==0 after a request before re-issuing it.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btnRaw  in  4  raw passenger buttons, bit i = floor i+1, asynchronous level
- floorSel  in  2  current floor from the controller, 0 = floor 1
- door  in  1  controller door status, 1 = open
- floorBtn  out  4  one-hot request to the controller, valid for exactly one cycle
- pending  out  4  lit call lamps, bit i = floor i+1 outstanding
- seg  out  7  GFEDCBA, active-low, shows floorSel+1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Input capture: 2-flop synchronizer per bit, then rising-edge detect (sync2 & ~prev). A raw press sets pending[i] on the 3rd rising clk edge after btnRaw[i] goes high. A held button registers once.
- Clearing: pending[i] clears on any cycle with door==1 && floorSel==i, in every state. If set and clear coincide, clear wins, so a press at the open current floor never lights.
- Target selection (combinational, from pending with current floor masked out):
  - dir=up: lowest pending floor above floorSel; else highest pending below, and dir flips to down.
  - dir=down: mirror of the up rule.
  - dir updates only on the transition into ISSUE.
- FSM states: IDLE, DWELL, ISSUE, WAIT_LEAVE, WAIT_ARRIVE.
  - IDLE: if door==1, load the dwell counter and go to DWELL.
  - DWELL:
    - Counter decrements while door==1; if door==0, return to IDLE.
    - When the count reaches 0 and a target exists, latch target and go to ISSUE.
    - With no target, stay in DWELL holding 0.
  - ISSUE (1 cycle): floorBtn = one-hot(target). Load the leave counter and go to WAIT_LEAVE.
  - WAIT_LEAVE:
    - door==0: go to WAIT_ARRIVE.
    - Leave counter expires with door still 1: go back to ISSUE (retry, unbounded).
  - WAIT_ARRIVE: door==1 && floorSel==target: go to IDLE; the target's pending bit clears by the clearing rule.
  - floorBtn is 0 in every state except ISSUE. It is never the current floor and never multi-hot.
- The dwell requirement exists because the controller ignores new requests for one cycle after arriving at a floor; DWELL_CYCLES<2 is illegal.
- seg encoding (active-low), driven combinationally every cycle including reset:
  - floor 1: 1111001
  - floor 2: 0100100
  - floor 3: 0110000
  - floor 4: 0011001
- Reset values: state=IDLE, pending=0, dir=up, target=0, counters=0, sync/prev flops=0, floorBtn=0, busy=0.
- Reset mid-operation discards all calls; the controller is reset alongside and returns to floor 1, door open.
- Presses arriving during any state accumulate in pending and are served in later SCAN passes.

Test Plan:
- Basic call:
  - Stimulus: reset; controller at floor 1, door open; pulse btnRaw=0100.
  - Response: pending=0100 at 3rd edge. After DWELL_CYCLES, floorBtn=0100 for 1 cycle. busy=1. On arrival at floorSel=2'b10 with door=1, pending=0000 and FSM reaches IDLE. seg=0110000.
- Current floor ignored: at floor 2 with door open, press btnRaw=0010 → pending stays 0000, floorBtn never asserts.
- SCAN order:
  - Stimulus: at floor 2 moving up, pending=1001.
  - Response: floorBtn=1000 first. After arrival at floor 4 and dwell, floorBtn=0001 with dir=down.
- Accumulation: while in WAIT_ARRIVE toward floor 4, press floor 3 → pending=1100. Floor 3 is served only after the floor-4 arrival, because the car passes floor 3 with door==0.
- Retry: stub controller holds door=1 after the request → floorBtn re-pulses every LEAVE_TIMEOUT+1 cycles until door drops.
- Reset mid-trip: assert rst in WAIT_ARRIVE with pending=1010 → next cycle pending=0000, floorBtn=0000, busy=0, dir=up.

Source files
------------

// File: rtl/elev_call_panel.sv
// Passenger call panel: button capture, pending call lamps, SCAN target
// selection, request handshake with the elevator controller, floor display.
module elev_call_panel #(
  parameter int unsigned DWELL_CYCLES  = 4,  // must be >= 2
  parameter int unsigned LEAVE_TIMEOUT = 3   // must be >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btnRaw,
  input  logic [1:0] floorSel,
  input  logic       door,
  output logic [3:0] floorBtn,
  output logic [3:0] pending,
  output logic [6:0] seg,
  output logic       busy
);

  localparam int unsigned N_FLOORS = 4;
  localparam int unsigned CNT_MAX  = (DWELL_CYCLES > LEAVE_TIMEOUT) ? DWELL_CYCLES : LEAVE_TIMEOUT;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DWELL       = 3'd1,
    S_ISSUE       = 3'd2,
    S_WAIT_LEAVE  = 3'd3,
    S_WAIT_ARRIVE = 3'd4
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  state_e               state_q, state_d;
  dir_e                 dir_q, dir_d, sel_dir;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           target_q, target_d, sel_tgt;
  logic [N_FLOORS-1:0]  sync1_q, sync2_q, prev_q;
  logic [N_FLOORS-1:0]  rise, clr, masked;
  logic [1:0]           lo_above, hi_below;
  logic                 found_above, found_below, has_tgt;

  assign rise   = sync2_q & ~prev_q;
  assign clr    = door ? (4'b0001 << floorSel) : 4'b0000;
  assign masked = pending & ~(4'b0001 << floorSel);

  // Button synchronizer, edge detect and pending lamps; clearing beats setting
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pending <= '0;
    end else begin
      sync1_q <= btnRaw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pending <= (pending | rise) & ~clr;
    end
  end

  // SCAN pick: nearest call ahead in the current direction, else reverse
  always_comb begin
    lo_above    = 2'd0;
    hi_below    = 2'd0;
    found_above = 1'b0;
    found_below = 1'b0;
    sel_tgt     = 2'd0;
    sel_dir     = dir_q;
    for (int i = 0; i < int'(N_FLOORS); i++) begin
      if (masked[i] && (2'(i) > floorSel) && !found_above) begin
        lo_above    = 2'(i);
        found_above = 1'b1;
      end
    end
    for (int i = int'(N_FLOORS) - 1; i >= 0; i--) begin
      if (masked[i] && (2'(i) < floorSel) && !found_below) begin
        hi_below    = 2'(i);
        found_below = 1'b1;
      end
    end
    if (dir_q == DIR_UP) begin
      if (found_above) begin
        sel_tgt = lo_above;
        sel_dir = DIR_UP;
      end else if (found_below) begin
        sel_tgt = hi_below;
        sel_dir = DIR_DOWN;
      end
    end else begin
      if (found_below) begin
        sel_tgt = hi_below;
        sel_dir = DIR_DOWN;
      end else if (found_above) begin
        sel_tgt = lo_above;
        sel_dir = DIR_UP;
      end
    end
    has_tgt = found_above | found_below;
  end

  // Next-state: dwell at a floor, issue request, wait to leave, wait to arrive
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    dir_d    = dir_q;
    case (state_q)
      S_IDLE: begin
        if (door) begin
          state_d = S_DWELL;
          cnt_d   = CNT_W'(DWELL_CYCLES - 1);
        end
      end
      S_DWELL: begin
        if (!door) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (has_tgt) begin
          state_d  = S_ISSUE;
          target_d = sel_tgt;
          dir_d    = sel_dir;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_LEAVE;
        cnt_d   = CNT_W'(LEAVE_TIMEOUT - 1);
      end
      S_WAIT_LEAVE: begin
        if (!door) begin
          state_d = S_WAIT_ARRIVE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_ARRIVE: begin
        if (door && (floorSel == target_q)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state plus registered request pulse and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      target_q <= 2'd0;
      dir_q    <= DIR_UP;
      floorBtn <= 4'b0000;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      floorBtn <= (state_d == S_ISSUE) ? (4'b0001 << target_d) : 4'b0000;
      busy     <= (state_d != S_IDLE);
    end
  end

  // Active-low GFEDCBA floor indicator, showing floorSel+1
  always_comb begin
    case (floorSel)
      2'd0:    seg = 7'b1111001;
      2'd1:    seg = 7'b0100100;
      2'd2:    seg = 7'b0110000;
      default: seg = 7'b0011001;
    endcase
  end

endmodule
